// File: rtl/ram_wr_arb_2wr.sv
// Two-channel round-robin RAM write arbiter with optional table clear sweep (RAM_WR_ARB_CLEAR_EN).
// Latency: accepted request appears on wea/addra/dina one cycle after the valid&ready transfer.
// Backpressure: ready is granted to one channel per cycle by rr_ptr; both readies drop during clear/reset.
module ram_wr_arb_2wr #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 16,
  // Equivalent to clogb2(RAM_DEPTH-1): bits needed to hold the highest index.
  localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic                 clka,
  input  logic                 rstb,
  input  logic                 s0_valid,
  output logic                 s0_ready,
  input  logic [AW-1:0]        s0_addr,
  input  logic [RAM_WIDTH-1:0] s0_data,
  input  logic                 s1_valid,
  output logic                 s1_ready,
  input  logic [AW-1:0]        s1_addr,
  input  logic [RAM_WIDTH-1:0] s1_data,
  output logic                 wea,
  output logic [AW-1:0]        addra,
  output logic [RAM_WIDTH-1:0] dina,
  output logic                 err_addr,
  output logic [15:0]          wr_cnt,
  input  logic                 clr_start,
  output logic                 clr_done,
  output logic                 busy
);

  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(RAM_DEPTH);
  localparam logic [15:0]   CNT_MAX   = 16'hFFFF;

  logic                 rr_ptr_q, rr_ptr_d;
  logic                 wea_q, wea_d;
  logic [AW-1:0]        addra_q, addra_d;
  logic [RAM_WIDTH-1:0] dina_q, dina_d;
  logic                 err_addr_q, err_addr_d;
  logic [15:0]          wr_cnt_q, wr_cnt_d;

  logic                 in_arb;
  logic                 clr_req;
  logic                 grant0, grant1;
  logic [AW-1:0]        sel_addr;
  logic [RAM_WIDTH-1:0] sel_data;
  logic                 sel_in_range;

`ifdef RAM_WR_ARB_CLEAR_EN
  localparam logic [0:0]    ST_ARB    = 1'b0;
  localparam logic [0:0]    ST_CLEAR  = 1'b1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH-1);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          clr_done_q, clr_done_d;
  logic          busy_q, busy_d;

  assign in_arb   = (state_q == ST_ARB);
  assign clr_req  = clr_start;
  assign clr_done = clr_done_q;
  assign busy     = busy_q;
`else
  logic unused_clr_start;

  assign unused_clr_start = clr_start;
  assign in_arb   = 1'b1;
  assign clr_req  = 1'b0;
  assign clr_done = 1'b0;
  assign busy     = 1'b0;
`endif

  // A channel's ready depends only on the other channel's valid and the pointer.
  assign s0_ready = !rstb && in_arb && !clr_req && (!s1_valid || !rr_ptr_q);
  assign s1_ready = !rstb && in_arb && !clr_req && (!s0_valid ||  rr_ptr_q);
  assign grant0   = s0_valid && s0_ready;
  assign grant1   = s1_valid && s1_ready;

  assign sel_addr     = grant1 ? s1_addr : s0_addr;
  assign sel_data     = grant1 ? s1_data : s0_data;
  assign sel_in_range = ({1'b0, sel_addr} < DEPTH_W);

  assign wea      = wea_q;
  assign addra    = addra_q;
  assign dina     = dina_q;
  assign err_addr = err_addr_q;
  assign wr_cnt   = wr_cnt_q;

  // Next-state: arbitration, write register, error pulse, counter, clear sweep.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    wea_d      = 1'b0;
    addra_d    = addra_q;
    dina_d     = dina_q;
    err_addr_d = 1'b0;
    wr_cnt_d   = wr_cnt_q;

    if (grant0) begin
      rr_ptr_d = 1'b1;
    end else if (grant1) begin
      rr_ptr_d = 1'b0;
    end

    if (grant0 || grant1) begin
      if (sel_in_range) begin
        wea_d   = 1'b1;
        addra_d = sel_addr;
        dina_d  = sel_data;
        if (wr_cnt_q != CNT_MAX) begin
          wr_cnt_d = wr_cnt_q + 16'd1;
        end
      end else begin
        err_addr_d = 1'b1;
      end
    end

`ifdef RAM_WR_ARB_CLEAR_EN
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_done_d = 1'b0;
    busy_d     = busy_q;

    if (state_q == ST_ARB) begin
      // Readies are already low, so no request competes with the first clear write.
      if (clr_start) begin
        state_d    = ST_CLEAR;
        busy_d     = 1'b1;
        clr_addr_d = '0;
        wea_d      = 1'b1;
        addra_d    = '0;
        dina_d     = '0;
      end
    end else begin
      // clr_addr_q mirrors the address being written this cycle.
      if (clr_addr_q == LAST_ADDR) begin
        state_d    = ST_ARB;
        busy_d     = 1'b0;
        clr_done_d = 1'b1;
        clr_addr_d = '0;
      end else begin
        clr_addr_d = clr_addr_q + 1'b1;
        wea_d      = 1'b1;
        addra_d    = clr_addr_q + 1'b1;
        dina_d     = '0;
      end
    end
`endif
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clka) begin
    if (rstb) begin
      rr_ptr_q   <= 1'b0;
      wea_q      <= 1'b0;
      addra_q    <= '0;
      dina_q     <= '0;
      err_addr_q <= 1'b0;
      wr_cnt_q   <= '0;
`ifdef RAM_WR_ARB_CLEAR_EN
      state_q    <= ST_ARB;
      clr_addr_q <= '0;
      clr_done_q <= 1'b0;
      busy_q     <= 1'b0;
`endif
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wea_q      <= wea_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
      err_addr_q <= err_addr_d;
      wr_cnt_q   <= wr_cnt_d;
`ifdef RAM_WR_ARB_CLEAR_EN
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      clr_done_q <= clr_done_d;
      busy_q     <= busy_d;
`endif
    end
  end

endmodule

// File: doc/ram_wr_arb_2wr.md
RAM_WR_ARB_2WR -- requirements
Module: ram_wr_arb_2wr

Interface
REQ-001 SHALL have parameters: RAM_WIDTH, 32, write data width; RAM_DEPTH, 16, table entries; AW is derived as clogb2(RAM_DEPTH-1) and is the address width.
REQ-002 SHALL have ports (name direction width meaning): clka in 1 clock; rstb in 1 reset, synchronous, active-high; clock clka.
REQ-003 SHALL have ports: s0_valid in 1 ch0 request; s0_ready out 1 ch0 accept; s0_addr in AW ch0 address; s0_data in RAM_WIDTH ch0 data.
REQ-004 SHALL have ports: s1_valid, s1_ready, s1_addr, s1_data, identical to the ch0 ports for ch1.
REQ-005 SHALL have ports: wea out 1 RAM write enable; addra out AW RAM write address; dina out RAM_WIDTH RAM write data.
REQ-006 SHALL have ports: err_addr out 1 out-of-range pulse; wr_cnt out 16 count of performed writes; clr_start in 1 table clear request; clr_done out 1 clear-complete pulse; busy out 1 clear in progress.

Function
REQ-007 SHALL have two states: ARB (normal arbitration) and CLEAR (table sweep).
REQ-008 SHALL drive s0_ready = ARB & !clr_start & (!s1_valid | rr_ptr==0), and s1_ready = ARB & !clr_start & (!s0_valid | rr_ptr==1). Ready SHALL NOT depend on the channel's own valid.
REQ-009 SHALL accept at most one request per cycle. A channel transfers when valid&ready.
REQ-010 SHALL update the round-robin pointer rr_ptr to 1 after a ch0 transfer and to 0 after a ch1 transfer, and SHALL leave it unchanged on idle cycles.
REQ-011 SHALL register an accepted in-range request onto wea=1, addra, dina in the cycle after the transfer (latency 1). wea SHALL be high for exactly one cycle per transfer.
REQ-012 SHALL hold addra and dina at their last values while wea=0.
REQ-013 SHALL accept a request whose address is >= RAM_DEPTH, drop it (wea=0), and pulse err_addr for 1 cycle in the slot where wea would have asserted.
REQ-014 SHALL increment wr_cnt once per wea pulse caused by a channel request. wr_cnt SHALL saturate at 0xFFFF. Clear writes SHALL NOT be counted.
REQ-015 SHALL move from ARB to CLEAR on the cycle after clr_start=1 is sampled in ARB. clr_start SHALL take priority over same-cycle requests, whose ready is already 0.
REQ-016 SHALL, in CLEAR, write dina=0 to addra=0,1,...,RAM_DEPTH-1, one address per cycle with wea=1, keep s0_ready and s1_ready at 0, and hold busy=1.
REQ-017 SHALL, after the write to RAM_DEPTH-1, pulse clr_done for 1 cycle and return to ARB with busy=0.
REQ-018 SHALL ignore clr_start while in CLEAR.

Reset
REQ-019 SHALL, on rstb=1 at a clka edge, set state=ARB, rr_ptr=0, wea=0, addra=0, dina=0, err_addr=0, wr_cnt=0, clr_done=0, busy=0, and the clear address counter to 0.
REQ-020 SHALL abort a sweep when reset is asserted mid-clear. No clr_done SHALL be issued, and the block SHALL return to ARB.
REQ-021 SHALL hold s0_ready and s1_ready at 0 while rstb=1.

Configuration
REQ-022 SHALL compile in the CLEAR state and sweep logic only when macro RAM_WR_ARB_CLEAR_EN is defined.
REQ-023 SHALL, when RAM_WR_ARB_CLEAR_EN is undefined, ignore clr_start, tie clr_done and busy to 0, remove the clr_start term from ready, and leave REQ-008 to REQ-014 unchanged.

Verification
REQ-024 Both channels valid for 4 cycles after reset -> grants ch0,ch1,ch0,ch1; wea high 4 consecutive cycles starting 1 cycle after the first accept; wr_cnt=4.
REQ-025 s0 only, addr=5, data=0xDEADBEEF -> next cycle wea=1, addra=5, dina=0xDEADBEEF; then wea=0 with addra/dina held.
REQ-026 RAM_DEPTH=12, s1 addr=13 -> s1 accepted, wea=0, err_addr pulses 1 cycle, wr_cnt unchanged.
REQ-027 With RAM_WR_ARB_CLEAR_EN defined, clr_start together with s0_valid -> s0_ready=0, busy=1 for 16 cycles, writes 0 to addresses 0..15, clr_done pulses once, then s0 is accepted.
REQ-028 rstb pulsed at clear address 7 -> wea=0 and busy=0 next cycle, no clr_done, block in ARB. wr_cnt preset near 0xFFFF -> wr_cnt saturates at 0xFFFF.
